instruction_fetch: RTL and testbench

Instruction fetch unit for the TinyChip 9-bit core. It owns the program counter and reads a synchronous instruction memory. It presents each 9-bit instruction to `controller` over a valid/ready handshake, and takes back the controller's branch decision for the accepted instruction. Branch targets come from a small writable target lookup table, because 9-bit encodings cannot carry full addresses. Execution stops on the halt encoding.

---
 rtl/tinychip_pkg.sv | 16 +
 rtl/branch_target_lut.sv | 32 +++
 rtl/instruction_fetch.sv | 98 +++++++++
 tb/tb_instruction_fetch.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinychip_pkg.sv
// TinyChip shared definitions.
// Used by fetch, control_decoder and controller.
package tinychip_pkg;

  localparam int INSTR_WIDTH = 9;
  localparam logic [INSTR_WIDTH-1:0] HALT_INSTR = 9'h1FF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAPT,
    S_PRESENT,
    S_HALT
  } fetch_state_t;

endpackage

// File: rtl/branch_target_lut.sv
// Branch target table: absolute targets for 9-bit branches.
// One write port, one combinational read port.
module branch_target_lut #(
  parameter int PC_WIDTH  = 10,
  parameter int LUT_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we,
  input  logic [$clog2(LUT_DEPTH)-1:0] widx,
  input  logic [PC_WIDTH-1:0]          wdata,
  input  logic [$clog2(LUT_DEPTH)-1:0] ridx,
  output logic [PC_WIDTH-1:0]          rdata
);

  logic [PC_WIDTH-1:0] mem [LUT_DEPTH];

  // Entry storage; cleared on reset, written one entry per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Same-cycle write is not bypassed: readers see the old entry.
  assign rdata = mem[ridx];

endmodule

// File: rtl/instruction_fetch.sv
// TinyChip instruction fetch: PC, sync imem read, valid/ready
// presentation, LUT-based redirect and halt detection.
module instruction_fetch
  import tinychip_pkg::*;
#(
  parameter int                PC_WIDTH  = 10,
  parameter logic [PC_WIDTH-1:0] START_PC = '0,
  parameter int                LUT_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic [PC_WIDTH-1:0]          imem_addr,
  output logic                         imem_rd_en,
  input  logic [INSTR_WIDTH-1:0]       imem_rdata,
  output logic [INSTR_WIDTH-1:0]       instruction,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [PC_WIDTH-1:0]          pc,
  input  logic                         branch_taken,
  input  logic [$clog2(LUT_DEPTH)-1:0] branch_sel,
  input  logic                         lut_we,
  input  logic [$clog2(LUT_DEPTH)-1:0] lut_idx,
  input  logic [PC_WIDTH-1:0]          lut_wdata,
  output logic                         done
);

  fetch_state_t                state, state_nxt;
  logic [PC_WIDTH-1:0]         pc_q, pc_nxt;
  logic [INSTR_WIDTH-1:0]      ir_q, ir_nxt;
  logic [PC_WIDTH-1:0]         target;

  branch_target_lut #(
    .PC_WIDTH  (PC_WIDTH),
    .LUT_DEPTH (LUT_DEPTH)
  ) u_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we),
    .widx  (lut_idx),
    .wdata (lut_wdata),
    .ridx  (branch_sel),
    .rdata (target)
  );

  // State, PC and instruction registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      pc_q  <= START_PC;
      ir_q  <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      ir_q  <= ir_nxt;
    end
  end

  // Next state, next PC and instruction capture.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    ir_nxt    = ir_q;
    unique case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_nxt    = START_PC;
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        state_nxt = S_CAPT;
      end
      S_CAPT: begin
        ir_nxt    = imem_rdata;
        state_nxt = (imem_rdata == HALT_INSTR) ? S_HALT
                                               : S_PRESENT;
      end
      S_PRESENT: begin
        if (instr_ready) begin
          pc_nxt    = branch_taken ? target : pc_q + 1'b1;
          state_nxt = S_REQ;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = ir_q;
  assign imem_rd_en  = (state == S_REQ);
  assign instr_valid = (state == S_PRESENT);
  assign done        = (state == S_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch.
// Directed scenarios plus a randomized run against a model.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic [9:0] imem_addr;
  logic       imem_rd_en;
  logic [8:0] imem_rdata;
  logic [8:0] instruction;
  logic       instr_valid;
  logic       instr_ready;
  logic [9:0] pc;
  logic       branch_taken;
  logic [3:0] branch_sel;
  logic       lut_we;
  logic [3:0] lut_idx;
  logic [9:0] lut_wdata;
  logic       done;

  logic       start2;
  logic [9:0] addr2;
  logic       rd2;
  logic [8:0] rdata2;
  logic [8:0] instr2;
  logic       valid2;
  logic       ready2;
  logic [9:0] pc2;
  logic       done2;

  logic [8:0] rom  [1024];
  logic [8:0] rom2 [1024];

  int checks   = 0;
  int failures = 0;

  instruction_fetch #(
    .PC_WIDTH (10), .START_PC (10'h000), .LUT_DEPTH (16)
  ) dut (
    .clk (clk), .reset (reset), .start (start),
    .imem_addr (imem_addr), .imem_rd_en (imem_rd_en),
    .imem_rdata (imem_rdata), .instruction (instruction),
    .instr_valid (instr_valid), .instr_ready (instr_ready),
    .pc (pc), .branch_taken (branch_taken),
    .branch_sel (branch_sel), .lut_we (lut_we),
    .lut_idx (lut_idx), .lut_wdata (lut_wdata), .done (done)
  );

  instruction_fetch #(
    .PC_WIDTH (10), .START_PC (10'h3FF), .LUT_DEPTH (16)
  ) dut2 (
    .clk (clk), .reset (reset), .start (start2),
    .imem_addr (addr2), .imem_rd_en (rd2),
    .imem_rdata (rdata2), .instruction (instr2),
    .instr_valid (valid2), .instr_ready (ready2),
    .pc (pc2), .branch_taken (1'b0),
    .branch_sel (4'd0), .lut_we (1'b0),
    .lut_idx (4'd0), .lut_wdata (10'd0), .done (done2)
  );

  // synchronous instruction memories
  always @(posedge clk) if (imem_rd_en) imem_rdata <= rom[imem_addr];
  always @(posedge clk) if (rd2) rdata2 <= rom2[addr2];

  task automatic launch();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic write_lut(input logic [3:0] i, input logic [9:0] d);
    lut_we = 1'b1; lut_idx = i; lut_wdata = d;
    @(negedge clk);
    lut_we = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    instr_ready = 1'b1; branch_taken = 1'b0;
    while (!done && n < 50) begin
      @(negedge clk); n++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done: done=%b required 1", tag, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || done !== 1'b0 || imem_rd_en !== 1'b0
          || pc !== 10'h000 || instruction !== 9'h000) begin
        failures++;
        $display("FAIL reset_idle: v=%b d=%b rd=%b pc=%h ins=%h required 0s",
                 instr_valid, done, imem_rd_en, pc, instruction);
      end
    end
    start = 1'b1;
    checks++;
    if (imem_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL start_early: rd_en=%b required 0", imem_rd_en);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 10'h000) begin
      failures++;
      $display("FAIL start_req: rd_en=%b addr=%h required 1/000",
               imem_rd_en, imem_addr);
    end
    wait_done("reset");
  endtask

  task automatic test_sequential();
    int k = 0;
    instr_ready = 1'b1;
    launch();
    for (int cyc = 1; cyc <= 9; cyc++) begin
      if (cyc > 1) @(negedge clk);
      checks++;
      if (instr_valid !== (cyc % 3 == 0)) begin
        failures++;
        $display("FAIL seq_valid: cycle %0d valid=%b required %b",
                 cyc, instr_valid, cyc % 3 == 0);
      end
      if (cyc % 3 == 0) begin
        checks++;
        if (pc !== 10'(k) || instruction !== 9'(k + 1)) begin
          failures++;
          $display("FAIL seq_data: pc=%h ins=%h required %h/%h",
                   pc, instruction, 10'(k), 9'(k + 1));
        end
        k++;
      end
    end
    wait_done("seq");
  endtask

  task automatic test_backpressure();
    int n = 0;
    instr_ready = 1'b1;
    launch();
    while (!(instr_valid && pc == 10'd1) && n < 30) begin
      @(negedge clk); n++;
    end
    instr_ready = 1'b0;
    checks++;
    if (!(instr_valid && pc == 10'd1)) begin
      failures++;
      $display("FAIL bp_reach: valid=%b pc=%h required 1/001",
               instr_valid, pc);
    end
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instruction !== 9'h002
          || pc !== 10'd1 || imem_rd_en !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold: v=%b ins=%h pc=%h rd=%b required 1/002/001/0",
                 instr_valid, instruction, pc, imem_rd_en);
      end
    end
    instr_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 10'd2) begin
      failures++;
      $display("FAIL bp_release: rd=%b addr=%h required 1/002",
               imem_rd_en, imem_addr);
    end
    wait_done("bp");
  endtask

  task automatic branch_run(input logic wr, input logic [9:0] wd,
                            input logic [9:0] exp);
    int n = 0;
    instr_ready = 1'b1;
    launch();
    while (!(instr_valid && pc == 10'd2) && n < 30) begin
      @(negedge clk); n++;
    end
    branch_taken = 1'b1; branch_sel = 4'd3;
    if (wr) begin
      lut_we = 1'b1; lut_idx = 4'd3; lut_wdata = wd;
    end
    @(negedge clk);
    branch_taken = 1'b0; lut_we = 1'b0;
    checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== exp) begin
      failures++;
      $display("FAIL br_addr: rd=%b addr=%h required 1/%h",
               imem_rd_en, imem_addr, exp);
    end
    n = 0;
    while (!instr_valid && n < 10) begin
      @(negedge clk); n++;
    end
    checks++;
    if (instr_valid !== 1'b1 || pc !== exp || instruction !== rom[exp]) begin
      failures++;
      $display("FAIL br_present: v=%b pc=%h ins=%h required 1/%h/%h",
               instr_valid, pc, instruction, exp, rom[exp]);
    end
    wait_done("br");
  endtask

  task automatic test_branch();
    write_lut(4'd3, 10'h040);
    branch_run(1'b0, 10'h000, 10'h040);
    branch_run(1'b1, 10'h050, 10'h040);
    branch_run(1'b0, 10'h000, 10'h050);
  endtask

  task automatic test_halt_wrap();
    int n = 0;
    rom2[10'h3FF] = 9'h005;
    rom2[10'h000] = 9'h1FF;
    ready2 = 1'b1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    checks++;
    if (rd2 !== 1'b1 || addr2 !== 10'h3FF) begin
      failures++;
      $display("FAIL hw_req: rd=%b addr=%h required 1/3ff", rd2, addr2);
    end
    while (!valid2 && n < 10) begin
      @(negedge clk); n++;
    end
    checks++;
    if (valid2 !== 1'b1 || pc2 !== 10'h3FF || instr2 !== 9'h005) begin
      failures++;
      $display("FAIL hw_present: v=%b pc=%h ins=%h required 1/3ff/005",
               valid2, pc2, instr2);
    end
    @(negedge clk);
    checks++;
    if (rd2 !== 1'b1 || addr2 !== 10'h000) begin
      failures++;
      $display("FAIL hw_wrap: rd=%b addr=%h required 1/000", rd2, addr2);
    end
    @(negedge clk);
    checks++;
    if (done2 !== 1'b0 || valid2 !== 1'b0) begin
      failures++;
      $display("FAIL hw_capt: done=%b v=%b required 0/0", done2, valid2);
    end
    @(negedge clk);
    checks++;
    if (done2 !== 1'b1 || valid2 !== 1'b0) begin
      failures++;
      $display("FAIL hw_halt: done=%b v=%b required 1/0", done2, valid2);
    end
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    checks++;
    if (done2 !== 1'b0 || rd2 !== 1'b1 || addr2 !== 10'h3FF) begin
      failures++;
      $display("FAIL hw_restart: done=%b rd=%b addr=%h required 0/1/3ff",
               done2, rd2, addr2);
    end
  endtask

  task automatic test_random();
    logic [9:0] mlut [16];
    logic [9:0] mpc;
    logic [9:0] ppc;
    logic [8:0] pins;
    logic       pstall;
    logic       hs;
    int         since;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom_range(0, 510));
    for (int i = 0; i < 16; i++) begin
      mlut[i] = 10'($urandom);
      write_lut(4'(i), mlut[i]);
    end
    mpc = 10'h000; pstall = 1'b0; ppc = '0; pins = '0;
    instr_ready = 1'b1; branch_taken = 1'b0;
    launch();
    since = 1;
    for (int c = 0; c < 800; c++) begin
      if (c > 0) @(negedge clk);
      if (pstall) begin
        checks++;
        if (instr_valid !== 1'b1 || pc !== ppc || instruction !== pins) begin
          failures++;
          $display("FAIL rnd_stall: v=%b pc=%h ins=%h required 1/%h/%h",
                   instr_valid, pc, instruction, ppc, pins);
        end
      end
      if (since != 0) begin
        checks++;
        if (instr_valid !== (since == 3)) begin
          failures++;
          $display("FAIL rnd_gap: step %0d valid=%b required %b",
                   since, instr_valid, since == 3);
        end
      end
      if (imem_rd_en === 1'b1) begin
        checks++;
        if (imem_addr !== mpc) begin
          failures++;
          $display("FAIL rnd_addr: addr=%h required %h", imem_addr, mpc);
        end
      end
      instr_ready  = ($urandom % 4) != 0;
      branch_taken = ($urandom % 3) == 0;
      branch_sel   = 4'($urandom);
      lut_we       = ($urandom % 5) == 0;
      lut_idx      = 4'($urandom);
      lut_wdata    = 10'($urandom);
      hs = instr_valid && instr_ready;
      if (hs) begin
        checks++;
        if (pc !== mpc || instruction !== rom[mpc]) begin
          failures++;
          $display("FAIL rnd_present: pc=%h ins=%h required %h/%h",
                   pc, instruction, mpc, rom[mpc]);
        end
        mpc = branch_taken ? mlut[branch_sel] : mpc + 10'd1;
      end
      if (lut_we) mlut[lut_idx] = lut_wdata;
      pstall = instr_valid && !instr_ready;
      ppc    = pc;
      pins   = instruction;
      if (hs) since = 1;
      else if (since == 1 || since == 2) since++;
      else since = 0;
    end
    @(negedge clk);
    lut_we = 1'b0; branch_taken = 1'b0; instr_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    write_lut(4'd5, 10'h123);
    instr_ready = 1'b0;
    while (!instr_valid && n < 20) begin
      @(negedge clk); n++;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || done !== 1'b0 || imem_rd_en !== 1'b0
        || pc !== 10'h000 || instruction !== 9'h000) begin
      failures++;
      $display("FAIL mid_reset: v=%b d=%b rd=%b pc=%h ins=%h required 0s",
               instr_valid, done, imem_rd_en, pc, instruction);
    end
    @(negedge clk);
    reset = 1'b1;
    rom[0] = 9'h0CC;
    launch();
    checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 10'h000) begin
      failures++;
      $display("FAIL mid_restart: rd=%b addr=%h required 1/000",
               imem_rd_en, imem_addr);
    end
    n = 0;
    while (!instr_valid && n < 10) begin
      @(negedge clk); n++;
    end
    checks++;
    if (pc !== 10'h000 || instruction !== 9'h0CC) begin
      failures++;
      $display("FAIL mid_present: pc=%h ins=%h required 000/0cc",
               pc, instruction);
    end
    instr_ready = 1'b1; branch_taken = 1'b1; branch_sel = 4'd5;
    @(negedge clk);
    branch_taken = 1'b0;
    checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== 10'h000) begin
      failures++;
      $display("FAIL mid_lut_clear: rd=%b addr=%h required 1/000",
               imem_rd_en, imem_addr);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; start2 = 1'b0; ready2 = 1'b1;
    instr_ready = 1'b1; branch_taken = 1'b0; branch_sel = '0;
    lut_we = 1'b0; lut_idx = '0; lut_wdata = '0;
    for (int i = 0; i < 1024; i++) begin
      rom[i]  = 9'h1FF;
      rom2[i] = 9'h1FF;
    end
    rom[0] = 9'h001; rom[1] = 9'h002; rom[2] = 9'h003;
    rom[10'h040] = 9'h0AA;
    rom[10'h050] = 9'h0BB;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_backpressure();
    test_branch();
    test_halt_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
